rcfwl_gclk_clkreq_rsp: RTL and testbench

RCFWL_GCLK_CLKREQ_RSP -- requirements
Module: rcfwl_gclk_clkreq_rsp

---
 rtl/rcfwl_gclk_pkg.sv | 16 +
 rtl/rcfwl_gclk_dlycnt.sv | 39 +++
 rtl/rcfwl_gclk_clkreq_rsp.sv | 132 +++++++++++++
 tb/tb_rcfwl_gclk_clkreq_rsp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rcfwl_gclk_pkg.sv
// Shared state encoding and small helpers for the clock-request responder.
package rcfwl_gclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HYST = 2'd3
  } gclk_state_e;

  // Acknowledge is held in both the running and the hysteresis state.
  function automatic logic state_acked(input gclk_state_e s);
    return (s == ST_ON) || (s == ST_HYST);
  endfunction

endpackage

// File: rtl/rcfwl_gclk_dlycnt.sv
// Load / saturating-decrement / zero-detect delay counter shared by WAKE and HYST.
module rcfwl_gclk_dlycnt #(
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [DLY_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DLY_W-1:0] cnt_q;
  logic [DLY_W-1:0] cnt_d;

  // Next count: load wins, decrement stops at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {DLY_W{1'b0}})) begin
      cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {DLY_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {DLY_W{1'b0}});

endmodule

// File: rtl/rcfwl_gclk_clkreq_rsp.sv
// Responder side of the four-phase clkreq/clkack handshake with ungate and
// hysteresis delays, clock-enable output and a sticky protocol-error flag.
module rcfwl_gclk_clkreq_rsp
  import rcfwl_gclk_pkg::*;
#(
  parameter int DLY_W     = 4,
  parameter bit FORCE_ACK = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkreq,
  input  logic [DLY_W-1:0] cfg_on_dly,
  input  logic [DLY_W-1:0] cfg_off_dly,
  input  logic             cfg_force_on,
  input  logic             err_clr,
  output logic             clkack,
  output logic             clk_en,
  output logic [1:0]       state,
  output logic             proto_err
);

  gclk_state_e      state_q;
  gclk_state_e      state_d;
  logic             clkack_q;
  logic             clkack_d;
  logic             clk_en_q;
  logic             clk_en_d;
  logic             proto_err_q;
  logic             proto_err_d;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [DLY_W-1:0] cnt_val_s;
  logic             cnt_zero_s;
  logic             err_set_s;

  rcfwl_gclk_dlycnt #(
    .DLY_W(DLY_W)
  ) u_dlycnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load_s),
    .dec_i     (cnt_dec_s),
    .load_val_i(cnt_val_s),
    .zero_o    (cnt_zero_s)
  );

  // Next-state logic; config is only captured on the counter load cycle.
  always_comb begin
    state_d    = state_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = cfg_on_dly;
    err_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clkreq) begin
          state_d    = ST_WAKE;
          cnt_load_s = 1'b1;
          cnt_val_s  = cfg_on_dly;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAKE: begin
        // Requester withdrew before being acknowledged: flag it, keep waking.
        err_set_s = ~clkreq;
        if (cnt_zero_s) begin
          state_d = ST_ON;
        end else begin
          cnt_dec_s = 1'b1;
          state_d   = ST_WAKE;
        end
      end
      ST_ON: begin
        if (!clkreq) begin
          state_d    = ST_HYST;
          cnt_load_s = 1'b1;
          cnt_val_s  = cfg_off_dly;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_HYST: begin
        // Re-request before ack dropped: flag it, still finish gating.
        err_set_s = clkreq;
        if (cnt_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
          state_d   = ST_HYST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values derived from the next state so outputs are registered.
  always_comb begin
    clkack_d = state_acked(state_d) | (FORCE_ACK & cfg_force_on);
    clk_en_d = (state_d != ST_IDLE) | cfg_force_on;
    if (err_set_s) begin
      proto_err_d = 1'b1;
    end else if (err_clr) begin
      proto_err_d = 1'b0;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clkack_q    <= 1'b0;
      clk_en_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clkack_q    <= clkack_d;
      clk_en_q    <= clk_en_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign clkack    = clkack_q;
  assign clk_en    = clk_en_q;
  assign state     = state_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rcfwl_gclk_clkreq_rsp.sv
// Directed and randomized bench for the clock-request responder, checked
// against a cycle-countdown reference model.
module tb_rcfwl_gclk_clkreq_rsp;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkreq;
  logic [3:0] on_dly;
  logic [3:0] off_dly;
  logic       force_on;
  logic       err_clr;

  logic       ack0, en0, err0;
  logic [1:0] st0;
  logic       ack1, en1, err1;
  logic [1:0] st1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode 0 asleep, 1 waking, 2 awake, 3 cooling down;
  // m_left counts edges remaining until the next mode change.
  int m_mode = 0;
  int m_left = 0;
  bit m_err  = 1'b0;
  bit m_en   = 1'b0;
  bit m_ack0 = 1'b0;
  bit m_ack1 = 1'b0;

  // Observed event timestamps used for latency checks.
  int en_rise, ack_rise, ack_fall, en_fall, hyst_at, req_at, idle_obs;
  logic prev_en = 1'b0, prev_ack = 1'b0;
  logic [1:0] prev_st = 2'd0;

  rcfwl_gclk_clkreq_rsp #(.DLY_W(4), .FORCE_ACK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clkreq(clkreq), .cfg_on_dly(on_dly),
    .cfg_off_dly(off_dly), .cfg_force_on(force_on), .err_clr(err_clr),
    .clkack(ack0), .clk_en(en0), .state(st0), .proto_err(err0)
  );

  rcfwl_gclk_clkreq_rsp #(.DLY_W(4), .FORCE_ACK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clkreq(clkreq), .cfg_on_dly(on_dly),
    .cfg_off_dly(off_dly), .cfg_force_on(force_on), .err_clr(err_clr),
    .clkack(ack1), .clk_en(en1), .state(st1), .proto_err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_marks();
    en_rise = -1; ack_rise = -1; ack_fall = -1; en_fall = -1;
    hyst_at = -1; idle_obs = 0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit set;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_mode = 0; m_left = 0; m_err = 1'b0;
    end else begin
      set = (m_mode == 1 && !clkreq) || (m_mode == 3 && clkreq);
      case (m_mode)
        0: if (clkreq) begin m_mode = 1; m_left = int'(on_dly) + 1; end
        1: begin m_left--; if (m_left == 0) m_mode = 2; end
        2: if (!clkreq) begin m_mode = 3; m_left = int'(off_dly) + 1; end
        3: begin m_left--; if (m_left == 0) m_mode = 0; end
        default: m_mode = 0;
      endcase
      if (set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    m_en   = !rst && (m_mode != 0 || force_on);
    m_ack0 = !rst && (m_mode == 2 || m_mode == 3);
    m_ack1 = !rst && (m_mode == 2 || m_mode == 3 || force_on);
    chk("state", {30'd0, st0}, m_mode);
    chk("clk_en", {31'd0, en0}, {31'd0, m_en});
    chk("clkack", {31'd0, ack0}, {31'd0, m_ack0});
    chk("proto_err", {31'd0, err0}, {31'd0, m_err});
    chk("clkack_fa", {31'd0, ack1}, {31'd0, m_ack1});
    if (!prev_en && en0) en_rise = cyc;
    if (prev_en && !en0) en_fall = cyc;
    if (!prev_ack && ack0) ack_rise = cyc;
    if (prev_ack && !ack0) ack_fall = cyc;
    if (prev_st != 2'd3 && st0 == 2'd3) hyst_at = cyc;
    if (st0 == 2'd0) idle_obs++;
    prev_en = en0; prev_ack = ack0; prev_st = st0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Full request/release pulse with latency checks on both phases.
  task automatic handshake(input string tag, input logic [3:0] on_v, input logic [3:0] off_v, input int hold);
    on_dly = on_v; off_dly = off_v;
    clr_marks();
    clkreq = 1'b1; req_at = cyc;
    run(hold);
    clkreq = 1'b0;
    run(int'(off_v) + 4);
    chk({tag, "_en_lat"}, en_rise - req_at, 1);
    chk({tag, "_ack_lat"}, ack_rise - en_rise, int'(on_v) + 1);
    chk({tag, "_off_lat"}, ack_fall - hyst_at, int'(off_v) + 1);
    chk({tag, "_en_fall"}, en_fall, ack_fall);
  endtask

  initial begin
    rst = 1'b1; clkreq = 1'b0; on_dly = 4'd0; off_dly = 4'd0;
    force_on = 1'b0; err_clr = 1'b0;
    run(2);
    rst = 1'b0;
    run(2);

    // Basic, zero-delay and maximum-delay handshakes.
    handshake("basic", 4'd3, 4'd2, 20);
    chk("basic_err", {31'd0, err0}, 32'd0);
    handshake("zero", 4'd0, 4'd0, 6);
    handshake("max", 4'd15, 4'd1, 24);

    // Request withdrawn during WAKE.
    on_dly = 4'd5; off_dly = 4'd1;
    clkreq = 1'b1; step();
    clkreq = 1'b0; run(12);
    chk("wake_viol_err", {31'd0, err0}, 32'd1);
    chk("wake_viol_idle", {30'd0, st0}, 32'd0);
    err_clr = 1'b1; step();
    err_clr = 1'b0; step();
    chk("err_cleared", {31'd0, err0}, 32'd0);

    // Re-request during HYST: exactly one IDLE cycle before waking again.
    on_dly = 4'd1; off_dly = 4'd4;
    clkreq = 1'b1; run(5);
    clkreq = 1'b0; run(2);
    clr_marks();
    clkreq = 1'b1; run(10);
    chk("hyst_viol_err", {31'd0, err0}, 32'd1);
    chk("hyst_idle_cycles", idle_obs, 1);
    chk("hyst_rewake_ack", {31'd0, ack0}, 32'd1);
    clkreq = 1'b0; err_clr = 1'b1; run(8);
    err_clr = 1'b0;

    // Reset in the middle of ON, then restart with request held.
    on_dly = 4'd2;
    clkreq = 1'b1; run(6);
    rst = 1'b1; step();
    chk("rst_all", {28'd0, ack0, en0, err0, |st0}, 32'd0);
    rst = 1'b0; step();
    chk("rst_rewake", {30'd0, st0}, 32'd1);
    clkreq = 1'b0; run(10);

    // Force-on from IDLE.
    force_on = 1'b1; step();
    chk("force_en", {31'd0, en0}, 32'd1);
    chk("force_ack0", {31'd0, ack0}, 32'd0);
    chk("force_ack1", {31'd0, ack1}, 32'd1);
    force_on = 1'b0; run(2);

    // Randomized traffic including mid-count config changes and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) clkreq = ~clkreq;
      on_dly   = 4'($urandom_range(0, 6));
      off_dly  = 4'($urandom_range(0, 6));
      force_on = ($urandom_range(0, 15) == 0);
      err_clr  = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
